// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Data has fixed priority over IF; a halt request drains the in-flight access before stopping.

module mem_port_arbiter_chk #(
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  input logic mem_en
);
  logic mem_en_q_r;

  // Delayed copy of the strobe for the back-to-back check.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q_r <= 1'b0;
    end else begin
      mem_en_q_r <= mem_en;
    end
  end

  // Latency must fit the 4-bit wait counter; strobes are always separated.
  always @(posedge clk) begin
    if (!reset) begin
      lat_ok: assert (MEM_LAT >= 1 && MEM_LAT <= 15)
        else $error("mem_port_arbiter: MEM_LAT %0d outside 1..15", MEM_LAT);
      strobe_ok: assert (!(mem_en && mem_en_q_r))
        else $error("mem_port_arbiter: mem_en high on consecutive cycles");
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  input  logic              halt_req,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r;
  logic              gnt_d_r, we_r, halt_pend_r;
  logic              mem_en_r, mem_we_r, if_done_r, d_done_r, halted_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, d_rdata_r;
  logic              d_req_s, grant_s, rd_last_s;

  assign d_req_s   = d_read | d_write;
  // ISSUE is only ever entered from IDLE, so this marks the grant cycle.
  assign grant_s   = (state_next_s == S_ISSUE);
  assign rd_last_s = (state_r == S_WAIT) && (cnt_r == 4'd0);

  // Next-state selection for the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (halt_req) begin
          state_next_s = S_HALTED;
        end else if (d_req_s || if_req) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE:  state_next_s = S_WAIT;
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_DONE: begin
        if (halt_pend_r || halt_req) begin
          state_next_s = S_HALTED;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_HALTED: state_next_s = S_HALTED;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // State, request capture, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      gnt_d_r     <= 1'b0;
      we_r        <= 1'b0;
      halt_pend_r <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      if_done_r   <= 1'b0;
      d_done_r    <= 1'b0;
      halted_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
    end else begin
      state_r   <= state_next_s;
      mem_en_r  <= grant_s;
      mem_we_r  <= grant_s & d_req_s & d_write;
      if_done_r <= rd_last_s & ~gnt_d_r;
      d_done_r  <= rd_last_s & gnt_d_r;
      halted_r  <= (state_next_s == S_HALTED);

      if (grant_s) begin
        gnt_d_r    <= d_req_s;
        we_r       <= d_req_s & d_write;
        mem_addr_r <= d_req_s ? d_addr : if_addr;
        if (d_req_s) begin
          mem_wdata_r <= d_wdata;
        end
      end

      if (state_r == S_ISSUE) begin
        cnt_r <= LAT_LOAD;
      end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end

      // Writes share the timing but never disturb the read-data registers.
      if (rd_last_s && !we_r) begin
        if (gnt_d_r) begin
          d_rdata_r <= mem_rdata;
        end else begin
          if_rdata_r <= mem_rdata;
        end
      end

      if ((state_r != S_IDLE) && halt_req) begin
        halt_pend_r <= 1'b1;
      end
    end
  end

  assign if_stall  = if_req & ~if_done_r;
  assign d_stall   = d_req_s & ~d_done_r;
  assign if_done   = if_done_r;
  assign d_done    = d_done_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign halted    = halted_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  mem_port_arbiter_chk #(.MEM_LAT(MEM_LAT)) u_chk (
    .clk    (clk),
    .reset  (reset),
    .mem_en (mem_en_r)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2 and one at MEM_LAT=1,
// each backed by a fixed-latency memory model.

module tb_mem_port_arbiter;
  logic        clk, reset;
  logic        if_req, d_read, d_write, halt_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, d_done, d_stall, halted, mem_en, mem_we;

  logic        if_req2, d_read2, d_write2, halt_req2;
  logic [31:0] if_addr2, d_addr2, d_wdata2;
  logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        if_done2, if_stall2, d_done2, d_stall2, halted2, mem_en2, mem_we2;

  logic [31:0] pipe1_a, pipe1_b, pipe2;
  int          checks = 0;
  int          failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .halt_req(halt_req), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u2 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_done(if_done2), .if_stall(if_stall2),
    .d_read(d_read2), .d_write(d_write2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_done(d_done2), .d_stall(d_stall2),
    .halt_req(halt_req2), .halted(halted2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0050_0093;
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Memory models: read data appears exactly MEM_LAT cycles after the strobe.
  always @(posedge clk) begin
    if (reset) begin
      pipe1_a <= 32'h0;
      pipe1_b <= 32'h0;
      pipe2   <= 32'h0;
    end else begin
      pipe1_a <= mem_en ? mem_fn(mem_addr) : 32'h0BAD_0BAD;
      pipe1_b <= pipe1_a;
      pipe2   <= mem_en2 ? mem_fn(mem_addr2) : 32'h0BAD_0BAD;
    end
  end
  assign mem_rdata  = pipe1_b;
  assign mem_rdata2 = pipe2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; halt_req = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    if_req2 = 1'b0; d_read2 = 1'b0; d_write2 = 1'b0; halt_req2 = 1'b0;
    if_addr2 = 32'h0; d_addr2 = 32'h0; d_wdata2 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_if_rdata", if_rdata, 32'h0);
    check_val("rst_d_rdata", d_rdata, 32'h0);
    check_val("rst_dones", {30'h0, if_done, d_done}, 32'h0);
    check_val("rst_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_halted", {31'h0, halted}, 32'h0);
    check_val("rst_u2_outs", {27'h0, mem_en2, mem_we2, d_done2, if_done2, halted2}, 32'h0);

    // Plain IF fetch.
    start_cycle();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) start_cycle();
      @(negedge clk);
      check_val($sformatf("t1_mem_en_c%0d", c), {31'h0, mem_en}, {31'h0, c == 1});
      check_val($sformatf("t1_mem_we_c%0d", c), {31'h0, mem_we}, 32'h0);
      check_val($sformatf("t1_if_done_c%0d", c), {31'h0, if_done}, {31'h0, c == 4});
      check_val($sformatf("t1_if_stall_c%0d", c), {31'h0, if_stall}, {31'h0, c < 4});
      if (c == 1) check_val("t1_mem_addr", mem_addr, 32'h40);
      if (c == 4) begin
        check_val("t1_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
      end
    end

    // Data and IF together: data first, IF on the next IDLE.
    start_cycle();
    d_read = 1'b1; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) start_cycle();
      @(negedge clk);
      check_val($sformatf("t2_mem_en_c%0d", c), {31'h0, mem_en}, {31'h0, (c == 1) || (c == 6)});
      check_val($sformatf("t2_d_done_c%0d", c), {31'h0, d_done}, {31'h0, c == 4});
      check_val($sformatf("t2_if_done_c%0d", c), {31'h0, if_done}, {31'h0, c == 9});
      check_val($sformatf("t2_if_stall_c%0d", c), {31'h0, if_stall}, {31'h0, c < 9});
      check_val($sformatf("t2_d_stall_c%0d", c), {31'h0, d_stall}, {31'h0, c < 4});
      if (c == 1) check_val("t2_mem_addr_d", mem_addr, 32'h100);
      if (c == 6) check_val("t2_mem_addr_if", mem_addr, 32'h44);
      if (c == 4) begin
        check_val("t2_d_rdata", d_rdata, 32'hC0DE_0100);
        d_read = 1'b0;
      end
      if (c == 9) begin
        check_val("t2_if_rdata", if_rdata, 32'hC0DE_0044);
        if_req = 1'b0;
      end
    end

    // Store: write strobe, no read-data update.
    start_cycle();
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) start_cycle();
      @(negedge clk);
      check_val($sformatf("t3_mem_en_c%0d", c), {31'h0, mem_en}, {31'h0, c == 1});
      check_val($sformatf("t3_mem_we_c%0d", c), {31'h0, mem_we}, {31'h0, c == 1});
      check_val($sformatf("t3_d_done_c%0d", c), {31'h0, d_done}, {31'h0, c == 4});
      if (c == 1) begin
        check_val("t3_mem_addr", mem_addr, 32'h200);
        check_val("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (c == 4) begin
        check_val("t3_d_rdata_held", d_rdata, 32'hC0DE_0100);
        d_write = 1'b0;
      end
    end

    // Halt pulse mid-fetch: access completes, then the arbiter stays halted.
    start_cycle();
    if_req = 1'b1; if_addr = 32'h48;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) start_cycle();
      if (c == 2) halt_req = 1'b1;
      if (c == 3) halt_req = 1'b0;
      if (c == 6) begin
        if_req = 1'b1; if_addr = 32'h4C;
      end
      @(negedge clk);
      check_val($sformatf("t4_if_done_c%0d", c), {31'h0, if_done}, {31'h0, c == 4});
      check_val($sformatf("t4_halted_c%0d", c), {31'h0, halted}, {31'h0, c >= 5});
      check_val($sformatf("t4_mem_en_c%0d", c), {31'h0, mem_en}, {31'h0, c == 1});
      if (c >= 6) check_val($sformatf("t4_if_stall_c%0d", c), {31'h0, if_stall}, 32'h1);
      if (c == 4) begin
        check_val("t4_if_rdata", if_rdata, 32'hC0DE_0048);
        if_req = 1'b0;
      end
    end

    // Leave HALTED, then reset in the middle of a load.
    start_cycle();
    reset = 1'b1; if_req = 1'b0;
    start_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("t5_halted_cleared", {31'h0, halted}, 32'h0);
    start_cycle();
    d_read = 1'b1; d_addr = 32'h104;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) start_cycle();
      if (c == 2) begin
        reset = 1'b1; d_read = 1'b0;
      end
      if (c == 3) reset = 1'b0;
      if (c == 7) begin
        d_read = 1'b1; d_addr = 32'h108;
      end
      @(negedge clk);
      if (c == 1) begin
        check_val("t5_mem_en_first", {31'h0, mem_en}, 32'h1);
        check_val("t5_mem_addr_first", mem_addr, 32'h104);
      end
      if (c == 3) begin
        check_val("t5_rst_mem_addr", mem_addr, 32'h0);
        check_val("t5_rst_mem_wdata", mem_wdata, 32'h0);
        check_val("t5_rst_rdata", if_rdata | d_rdata, 32'h0);
        check_val("t5_rst_flags", {26'h0, mem_en, mem_we, if_done, d_done, halted, d_stall}, 32'h0);
      end
      if (c >= 3) begin
        check_val($sformatf("t5_d_done_c%0d", c), {31'h0, d_done}, {31'h0, c == 11});
        check_val($sformatf("t5_mem_en_c%0d", c), {31'h0, mem_en}, {31'h0, c == 8});
      end
      if (c == 8) check_val("t5_mem_addr_new", mem_addr, 32'h108);
      if (c == 11) begin
        check_val("t5_d_rdata", d_rdata, 32'hC0DE_0108);
        d_read = 1'b0;
      end
    end

    // MEM_LAT=1 back-to-back loads on the second instance.
    start_cycle();
    d_read2 = 1'b1; d_addr2 = 32'h300;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) start_cycle();
      @(negedge clk);
      check_val($sformatf("t6_mem_en_c%0d", c), {31'h0, mem_en2}, {31'h0, (c % 4) == 1});
      check_val($sformatf("t6_d_done_c%0d", c), {31'h0, d_done2}, {31'h0, (c % 4) == 3});
      if (c == 3) check_val("t6_d_rdata", d_rdata2, 32'hC0DE_0300);
      if (c == 11) d_read2 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF) and the data requester (load/store, driven by MemRead/MemWrite).
- Sits between the pipeline's IF/MEM stages and the memory macro.
- Sequences each access with a small FSM, returns read data, and produces stall signals for the hazard logic.
- Supports a halt drain: on halt, no new accesses start; any in-flight access completes first.

Parameters:
- ADDR_W, 32, width of the byte address on both requesters and on the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF requests a read; held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req=1.
- if_rdata  out  DATA_W  fetched instruction; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req & ~if_done.
- d_read  in  1  load request (MemRead).
- d_write  in  1  store request (MemWrite).
- d_addr  in  ADDR_W  load/store address; stable while the request is held.
- d_wdata  in  DATA_W  store data; stable while the request is held.
- d_rdata  out  DATA_W  load data; valid when d_done=1.
- d_done  out  1  one-cycle completion pulse for data.
- d_stall  out  1  (d_read|d_write) & ~d_done.
- halt_req  in  1  Halt decoded; sampled every cycle.
- halted  out  1  drain complete; sticky until reset.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset value of every output is 0: if_rdata, d_rdata, if_done, d_done, mem_en, mem_we, mem_addr, mem_wdata, halted. State resets to IDLE and the wait counter to 0.
- Reset mid-access: the in-flight access is discarded; no done pulse is produced for it.
- Stall outputs are combinational from the request inputs and the registered done pulses; all other outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE, HALTED.
- IDLE transitions:
  - halt_req=1 -> HALTED.
  - else d_read|d_write -> ISSUE with data granted.
  - else if_req -> ISSUE with IF granted.
  - else stay in IDLE.
- Request capture: on leaving IDLE, the granted address, wdata and we are captured into internal registers. we = d_write, so a write wins if d_read and d_write are both high.
- ISSUE (1 cycle): mem_en=1, mem_we=we, mem_addr and mem_wdata come from the captured registers. Counter loads MEM_LAT-1. Next state is WAIT.
- WAIT: counter decrements each cycle.
  - When the counter is 0, mem_rdata is valid in that cycle and is captured into the granted requester's rdata register. Next state is DONE.
  - With MEM_LAT=1, WAIT lasts exactly one cycle.
  - Writes pass through the same timing; rdata is not updated for a write.
- DONE (1 cycle): the granted requester's done pulse is asserted. Next state is HALTED if halt_req has been seen since the grant, else IDLE.
- Latency: a request first seen in IDLE in cycle T gives mem_en in T+1 and done in T+2+MEM_LAT.
  - With MEM_LAT=2, done is in T+4.
  - The next grant is evaluated in cycle T+3+MEM_LAT.
- Priority: fixed, data over IF. Simultaneous d_read and if_req: data is served first, and IF is served on the following IDLE cycle.
- Starvation: IF starvation is impossible because the data requester advances after each d_done.
- Halt drain: halt_req is latched into a sticky pending flag.
  - A pending halt never aborts an access in flight.
  - HALTED: no grants, mem_en=0, halted=1. Stalls follow their formulas, so any held request stays stalled.
  - HALTED exits only on reset.
- Idle behaviour: while nothing is in flight, mem_en=0; mem_addr and mem_wdata hold their last values.
- rdata registers hold their value until the next read completes for the same requester.
- Counter width is 4 bits; MEM_LAT outside 1..15 is illegal (simulation assertion).

Test Plan:
- MEM_LAT=2: if_req=1, if_addr=0x40 in cycle 0, memory returns 0x00500093 -> mem_en=1, mem_we=0, mem_addr=0x40 in cycle 1; if_done=1 and if_rdata=0x00500093 in cycle 4; if_stall=1 in cycles 0-3 and 0 in cycle 4.
- Simultaneous requests in cycle 0: d_read at 0x100, if_req at 0x44 -> mem_addr=0x100 in cycle 1 and d_done in cycle 4; mem_addr=0x44 in cycle 6 and if_done in cycle 9.
- Store: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF -> one cycle with mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; d_done in cycle 4; d_rdata unchanged.
- Halt during an access: halt_req pulsed in cycle 2 of an IF access -> if_done still in cycle 4; halted=1 from cycle 5; a later if_req produces no mem_en and holds if_stall=1.
- Reset mid-access: reset=1 in cycle 2 of a load -> all outputs 0 in cycle 3; no d_done appears; a new load issues normally after reset is released.
- MEM_LAT=1 back-to-back loads -> d_done every 4 cycles; mem_en never high on consecutive cycles.
